// File: rtl/bp_resolve_queue.sv
// Resolution queue for the global-history branch predictor: holds in-flight
// predictions from Decode until Memory resolves them, then emits redirect/flush and PHT update.
module bp_resolve_queue #(
  parameter int DEPTH     = 4,
  parameter int PC_WIDTH  = 32,
  parameter int IDX_WIDTH = 7,
  parameter int CNT_WIDTH = 32
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 push_valid,
  input  logic                 push_taken,
  input  logic [PC_WIDTH-1:0]  push_target,
  input  logic [PC_WIDTH-1:0]  push_fallthru,
  input  logic [IDX_WIDTH-1:0] push_idx,
  output logic                 push_ready,
  input  logic                 res_valid,
  input  logic                 res_taken,
  output logic                 redirect_valid,
  output logic [PC_WIDTH-1:0]  redirect_pc,
  output logic                 upd_valid,
  output logic [IDX_WIDTH-1:0] upd_idx,
  output logic                 upd_taken,
  output logic                 empty,
  output logic                 underflow_err,
  output logic [CNT_WIDTH-1:0] branch_cnt,
  output logic [CNT_WIDTH-1:0] mispred_cnt
);
  localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam logic [PW:0] FULL = PW'(0) + (PW+1)'(DEPTH);

  typedef struct packed {
    logic                 taken;
    logic [PC_WIDTH-1:0]  target;
    logic [PC_WIDTH-1:0]  fallthru;
    logic [IDX_WIDTH-1:0] idx;
  } entry_t;

  entry_t        mem [DEPTH];
  logic [PW-1:0] wrPtr, rdPtr;
  logic [PW:0]   count;

  entry_t head;
  logic   pop, mispred, pushAcc;

  assign push_ready = (count != FULL);
  assign empty      = (count == '0);

  assign head    = mem[rdPtr];
  assign pop     = res_valid && !empty;
  assign mispred = pop && (res_taken != head.taken);
  // Anything pushed alongside a mispredict is wrong-path and is dropped.
  assign pushAcc = push_valid && push_ready && !mispred;

  always_ff @(posedge clk) begin
    if (pushAcc) mem[wrPtr] <= '{taken: push_taken, target: push_target,
                                 fallthru: push_fallthru, idx: push_idx};
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wrPtr <= '0;
      rdPtr <= '0;
      count <= '0;
    end else if (mispred) begin
      // Flush: every younger entry was fetched down the wrong path.
      wrPtr <= '0;
      rdPtr <= '0;
      count <= '0;
    end else begin
      if (pushAcc) wrPtr <= wrPtr + 1'b1;
      if (pop)     rdPtr <= rdPtr + 1'b1;
      case ({pushAcc, pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      redirect_valid <= 1'b0;
      redirect_pc    <= '0;
      upd_valid      <= 1'b0;
      upd_idx        <= '0;
      upd_taken      <= 1'b0;
      underflow_err  <= 1'b0;
      branch_cnt     <= '0;
      mispred_cnt    <= '0;
    end else begin
      redirect_valid <= mispred;
      upd_valid      <= pop;
      if (pop) begin
        redirect_pc <= res_taken ? head.target : head.fallthru;
        upd_idx     <= head.idx;
        upd_taken   <= res_taken;
        if (branch_cnt != '1) branch_cnt <= branch_cnt + 1'b1;
      end
      if (mispred && mispred_cnt != '1) mispred_cnt <= mispred_cnt + 1'b1;
      if (res_valid && empty) underflow_err <= 1'b1;
    end
  end
endmodule
